reg_status_file: RTL and testbench

- Architectural register file plus per-register rename status (busy bit and ROB tag) for the out-of-order RISC-V core.
- Receives rename requests from the ROB at dispatch and retirement writes from the ROB at commit.
- Answers two combinational source-operand lookups per cycle: either a committed value or the ROB tag of the pending producer.
- Acts as the responder on the ROB's rename/commit/operand interface.

---
 rtl/reg_status_file_if.sv | 31 +++
 rtl/reg_status_file.sv | 62 ++++++
 tb/tb_reg_status_file.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/reg_status_file_if.sv
// reg_status_file_if: ROB-side rename/commit/operand-lookup bundle for reg_status_file
interface reg_status_file_if #(
  parameter int XLEN     = 32,
  parameter int ROB_ID_W = 4
);
  logic                rdy;
  logic                clear_all;
  logic                rd_in_fg;
  logic [4:0]          rd_idxin_update;
  logic [ROB_ID_W-1:0] reorder_rear;
  logic                rd_out_fg;
  logic [4:0]          rd_idxout_update;
  logic [XLEN-1:0]     rd_val_update;
  logic [ROB_ID_W-1:0] reorder_front;
  logic [4:0]          rs1_addr;
  logic [4:0]          rs2_addr;
  logic                rs1_ready;
  logic [XLEN-1:0]     rs1_val;
  logic                rs2_ready;
  logic [XLEN-1:0]     rs2_val;
  modport master (
    output rdy, clear_all, rd_in_fg, rd_idxin_update, reorder_rear,
           rd_out_fg, rd_idxout_update, rd_val_update, reorder_front, rs1_addr, rs2_addr,
    input  rs1_ready, rs1_val, rs2_ready, rs2_val
  );
  modport slave (
    input  rdy, clear_all, rd_in_fg, rd_idxin_update, reorder_rear,
           rd_out_fg, rd_idxout_update, rd_val_update, reorder_front, rs1_addr, rs2_addr,
    output rs1_ready, rs1_val, rs2_ready, rs2_val
  );
endinterface

// File: rtl/reg_status_file.sv
// reg_status_file: architectural registers with busy/ROB-tag rename status and two combinational lookups.
// Define REGFILE_COMMIT_BYPASS_EN to forward a matching same-cycle commit value into the lookups.
module reg_status_file #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int ROB_ID_W = 4
) (
  input logic             clk,
  input logic             rst,
  reg_status_file_if.slave bus
);
  logic [NREG-1:0][XLEN-1:0]     value_q, value_d;
  logic [NREG-1:0]               busy_q, busy_d;
  logic [NREG-1:0][ROB_ID_W-1:0] tag_q, tag_d;
  always_comb begin
    value_d = value_q;
    busy_d  = busy_q;
    tag_d   = tag_q;
    if (bus.rdy) begin
      if (bus.rd_out_fg && bus.rd_idxout_update != '0) begin
        value_d[bus.rd_idxout_update] = bus.rd_val_update;
        if (tag_q[bus.rd_idxout_update] == bus.reorder_front) busy_d[bus.rd_idxout_update] = 1'b0;
      end
      // rename is applied after commit so a same-register rename keeps the entry busy with the new tag
      if (bus.clear_all) busy_d = '0;
      else if (bus.rd_in_fg && bus.rd_idxin_update != '0) begin
        busy_d[bus.rd_idxin_update] = 1'b1;
        tag_d[bus.rd_idxin_update]  = bus.reorder_rear;
      end
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      value_q <= '0;
      busy_q  <= '0;
      tag_q   <= '0;
    end else begin
      value_q <= value_d;
      busy_q  <= busy_d;
      tag_q   <= tag_d;
    end
  for (genvar i = 0; i < 2; i++) begin : g_src
    logic [4:0]      a;
    logic            r;
    logic [XLEN-1:0] v;
    assign a = (i == 0) ? bus.rs1_addr : bus.rs2_addr;
    always_comb begin
      r = (a == '0) || !busy_q[a];
      v = (a == '0) ? '0 : busy_q[a] ? XLEN'(tag_q[a]) : value_q[a];
`ifdef REGFILE_COMMIT_BYPASS_EN
      if (a != '0 && busy_q[a] && bus.rd_out_fg && bus.rd_idxout_update == a && tag_q[a] == bus.reorder_front) begin
        r = 1'b1;
        v = bus.rd_val_update;
      end
`endif
    end
  end
  assign bus.rs1_ready = g_src[0].r;
  assign bus.rs1_val   = g_src[0].v;
  assign bus.rs2_ready = g_src[1].r;
  assign bus.rs2_val   = g_src[1].v;
endmodule

// File: tb/tb_reg_status_file.sv
// tb_reg_status_file: scoreboard bench; directed scenarios plus randomized traffic against an array-based model.
module tb_reg_status_file;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  reg_status_file_if bus ();
  reg_status_file dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic rst, rdy, clr, ren;
    logic [4:0] ridx;
    logic [3:0] rear;
    logic com;
    logic [4:0] cidx;
    logic [31:0] cval;
    logic [3:0] front;
    logic [4:0] a1, a2;
  } stim_t;
  typedef struct {
    logic r1;
    logic [31:0] v1;
    logic r2;
    logic [31:0] v2;
    string nm;
  } exp_t;
  exp_t q[$];
  int total = 0;
  int bad = 0;
  logic [31:0] mval[32];
  logic        mbusy[32];
  logic [3:0]  mtag[32];
  stim_t prev;
  function automatic stim_t idle(input logic [4:0] a1, input logic [4:0] a2);
    stim_t n;
    n = '{rst:0, rdy:1, clr:0, ren:0, ridx:0, rear:0, com:0, cidx:0, cval:0, front:0, a1:a1, a2:a2};
    return n;
  endfunction
  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      mval[i] = 0;
      mbusy[i] = 0;
      mtag[i] = 0;
    end
  endtask
  task automatic model_step(input stim_t p);
    if (p.rst) model_reset();
    else if (p.rdy) begin
      if (p.com && p.cidx != 0) begin
        mval[p.cidx] = p.cval;
        if (mtag[p.cidx] == p.front) mbusy[p.cidx] = 0;
      end
      if (p.clr) for (int i = 0; i < 32; i++) mbusy[i] = 0;
      else if (p.ren && p.ridx != 0) begin
        mbusy[p.ridx] = 1;
        mtag[p.ridx] = p.rear;
      end
    end
  endtask
  function automatic logic [32:0] look(input stim_t n, input logic [4:0] a);
    if (a == 0) return {1'b1, 32'h0};
`ifdef REGFILE_COMMIT_BYPASS_EN
    if (mbusy[a] && n.com && n.cidx == a && mtag[a] == n.front) return {1'b1, n.cval};
`endif
    if (mbusy[a]) return {1'b0, 28'h0, mtag[a]};
    return {1'b1, mval[a]};
  endfunction
  task automatic drive(input stim_t n, input bit chk, input logic er, input logic [31:0] ev, input string nm);
    exp_t e;
    logic [32:0] l1, l2;
    @(posedge clk);
    #1;
    model_step(prev);
    rst = n.rst;
    bus.rdy = n.rdy;
    bus.clear_all = n.clr;
    bus.rd_in_fg = n.ren;
    bus.rd_idxin_update = n.ridx;
    bus.reorder_rear = n.rear;
    bus.rd_out_fg = n.com;
    bus.rd_idxout_update = n.cidx;
    bus.rd_val_update = n.cval;
    bus.reorder_front = n.front;
    bus.rs1_addr = n.a1;
    bus.rs2_addr = n.a2;
    if (n.rst) model_reset();
    l1 = look(n, n.a1);
    l2 = look(n, n.a2);
    e.r1 = chk ? er : l1[32];
    e.v1 = chk ? ev : l1[31:0];
    e.r2 = l2[32];
    e.v2 = l2[31:0];
    e.nm = nm;
    q.push_back(e);
    prev = n;
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        total += 2;
        if (bus.rs1_ready !== e.r1 || bus.rs1_val !== e.v1) begin
          bad++;
          $display("FAIL %s rs1: got ready=%0d val=%h expected ready=%0d val=%h", e.nm, bus.rs1_ready, bus.rs1_val, e.r1, e.v1);
        end
        if (bus.rs2_ready !== e.r2 || bus.rs2_val !== e.v2) begin
          bad++;
          $display("FAIL %s rs2: got ready=%0d val=%h expected ready=%0d val=%h", e.nm, bus.rs2_ready, bus.rs2_val, e.r2, e.v2);
        end
      end
    end
  end
  initial begin
    stim_t n;
    prev = idle(0, 0);
    prev.rst = 1;
    bus.rdy = 1; bus.clear_all = 0; bus.rd_in_fg = 0; bus.rd_idxin_update = 0; bus.reorder_rear = 0;
    bus.rd_out_fg = 0; bus.rd_idxout_update = 0; bus.rd_val_update = 0; bus.reorder_front = 0;
    bus.rs1_addr = 0; bus.rs2_addr = 0;
    model_reset();
    drive(idle(5, 0), 1, 1, 0, "after_reset");
    n = idle(5, 1); n.ren = 1; n.ridx = 5; n.rear = 3;
    drive(n, 1, 1, 0, "rename_not_visible");
    drive(idle(5, 0), 1, 0, 32'h3, "x5_renamed");
    n = idle(5, 0); n.com = 1; n.cidx = 5; n.cval = 32'hDEADBEEF; n.front = 3;
`ifdef REGFILE_COMMIT_BYPASS_EN
    drive(n, 1, 1, 32'hDEADBEEF, "x5_commit_bypass");
`else
    drive(n, 1, 0, 32'h3, "x5_commit_cycle");
`endif
    drive(idle(5, 0), 1, 1, 32'hDEADBEEF, "x5_committed");
    n = idle(7, 0); n.ren = 1; n.ridx = 7; n.rear = 2; drive(n, 0, 0, 0, "x7_ren2");
    n = idle(7, 0); n.ren = 1; n.ridx = 7; n.rear = 9; drive(n, 1, 0, 32'h2, "x7_ren9");
    n = idle(0, 7); n.com = 1; n.cidx = 7; n.cval = 32'h11; n.front = 2; drive(n, 0, 0, 0, "x7_stale_commit");
    drive(idle(7, 0), 1, 0, 32'h9, "x7_still_tag9");
    n = idle(0, 7); n.com = 1; n.cidx = 7; n.cval = 32'h22; n.front = 9; drive(n, 0, 0, 0, "x7_commit9");
    drive(idle(7, 0), 1, 1, 32'h22, "x7_committed");
    n = idle(0, 4); n.ren = 1; n.ridx = 4; n.rear = 6; drive(n, 0, 0, 0, "x4_ren6");
    n = idle(0, 4); n.ren = 1; n.ridx = 4; n.rear = 10; n.com = 1; n.cidx = 4; n.cval = 32'h55; n.front = 6;
    drive(n, 0, 0, 0, "x4_commit_and_ren");
    drive(idle(4, 0), 1, 0, 32'hA, "x4_rename_wins");
    n = idle(4, 0); n.clr = 1; drive(n, 1, 0, 32'hA, "clear_cycle");
    drive(idle(4, 0), 1, 1, 32'h55, "x4_value_kept");
    for (int i = 1; i <= 3; i++) begin
      n = idle(0, 0); n.ren = 1; n.ridx = 5'(i); n.rear = 4'(i); drive(n, 0, 0, 0, "ren123");
    end
    n = idle(2, 1); n.clr = 1; n.com = 1; n.cidx = 1; n.cval = 32'h80; n.front = 1; n.ren = 1; n.ridx = 6; n.rear = 5;
    drive(n, 1, 0, 32'h2, "clear_with_commit");
    drive(idle(1, 2), 1, 1, 32'h80, "x1_after_clear");
    drive(idle(2, 3), 1, 1, 32'h0, "x2_after_clear");
    drive(idle(6, 3), 1, 1, 32'h0, "x6_not_busy");
    n = idle(0, 0); n.ren = 1; n.ridx = 0; n.rear = 7; n.com = 1; n.cidx = 0; n.cval = 32'h99; drive(n, 0, 0, 0, "x0_write");
    drive(idle(0, 0), 1, 1, 32'h0, "x0_zero");
    n = idle(8, 0); n.rdy = 0; n.ren = 1; n.ridx = 8; n.rear = 4; n.com = 1; n.cidx = 8; n.cval = 32'h77;
    drive(n, 0, 0, 0, "rdy_low");
    drive(idle(8, 0), 1, 1, 32'h0, "x8_unchanged");
    n = idle(0, 0); n.ren = 1; n.ridx = 3; n.rear = 12; drive(n, 0, 0, 0, "x3_ren12");
    drive(idle(3, 0), 1, 0, 32'hC, "x3_busy");
    n = idle(3, 5); n.rst = 1; drive(n, 1, 1, 32'h0, "async_reset");
    for (int c = 0; c < 2000; c++) begin
      n.rst = ($urandom_range(0, 59) == 0);
      n.rdy = ($urandom_range(0, 7) != 0);
      n.clr = ($urandom_range(0, 19) == 0);
      n.ren = $urandom_range(0, 1);
      n.ridx = 5'($urandom_range(0, 7));
      n.rear = 4'($urandom);
      n.com = $urandom_range(0, 1);
      n.cidx = 5'($urandom_range(0, 7));
      n.cval = $urandom;
      n.front = $urandom_range(0, 2) != 0 ? mtag[n.cidx] : 4'($urandom);
      n.a1 = ($urandom_range(0, 1) != 0) ? n.cidx : 5'($urandom_range(0, 7));
      n.a2 = 5'($urandom_range(0, 7));
      drive(n, 0, 0, 0, "random");
    end
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
